machine_digit_scan: RTL and testbench

Time-multiplexing scanner for the four-digit seven-segment display. It accepts 16-bit display values over a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits. Each cycle it drives the 2-bit digit index consumed by `Machine_anode`, plus the selected hex nibble and decimal point for the segment decoder. A programmable blanking interval at the start of each digit slot suppresses ghosting.

---
 rtl/machine_disp_pkg.sv | 30 +++
 rtl/machine_scan_timer.sv | 70 +++++++
 rtl/machine_digit_scan.sv | 101 ++++++++++
 tb/tb_machine_digit_scan.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/machine_disp_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
package machine_disp_pkg;

    localparam int unsigned DIGITS = 4;

    // Per-slot phase: digit dark during BLANK to suppress ghosting, lit during SHOW.
    typedef enum logic {
        PhBlank,
        PhShow
    } phase_e;

    // One buffered display frame: decimal points plus four hex digits.
    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] value;
    } disp_word_t;

    // True when digit `sel` and every higher digit are zero; digit 0 is never hidden.
    function automatic logic lz_hidden(input logic [15:0] value, input logic [1:0] sel);
        logic hidden;
        unique case (sel)
            2'd3:    hidden = (value[15:12] == 4'h0);
            2'd2:    hidden = (value[15:8] == 8'h00);
            2'd1:    hidden = (value[15:4] == 12'h000);
            default: hidden = 1'b0;
        endcase
        return hidden;
    endfunction

endpackage

// File: rtl/machine_scan_timer.sv
// Slot counter, digit index and blank/show phase FSM for the digit scanner.
// Exposes next-state values so the top can register its outputs aligned
// with the digit index.
module machine_scan_timer
    import machine_disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       slot_end_o,
    output logic [1:0] digit_sel_o,
    output logic [1:0] digit_sel_next_o,
    output logic       show_next_o,
    output logic       frame_end_next_o
);

    localparam int unsigned CntW         = $clog2(PRESCALE);
    localparam int unsigned BlankLastInt = (BLANK == 0) ? 0 : BLANK - 1;
    localparam logic [CntW-1:0] SlotLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankLastInt);
    localparam logic [1:0]      SelLast   = 2'(DIGITS - 1);

    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]      sel_q, sel_d;
    phase_e          phase_q, phase_d;
    logic            slot_end;

    // Next-state: counter wrap, digit advance at slot end, phase transitions.
    always_comb begin
        slot_end   = (slot_cnt_q == SlotLast);
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + CntW'(1);
        sel_d      = slot_end ? sel_q + 2'd1 : sel_q;
        phase_d    = phase_q;
        unique case (phase_q)
            PhBlank: begin
                if (BLANK == 0 || slot_cnt_q == BlankLast) begin
                    phase_d = PhShow;
                end
            end
            PhShow: begin
                // With no blanking interval the digit stays lit across slots.
                if (slot_end && BLANK != 0) begin
                    phase_d = PhBlank;
                end
            end
        endcase
    end

    // Timer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_cnt_q <= '0;
            sel_q      <= '0;
            phase_q    <= PhBlank;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            sel_q      <= sel_d;
            phase_q    <= phase_d;
        end
    end

    assign slot_end_o       = slot_end;
    assign digit_sel_o      = sel_q;
    assign digit_sel_next_o = sel_d;
    assign show_next_o      = (phase_d == PhShow);
    assign frame_end_next_o = (slot_cnt_d == SlotLast) && (sel_d == SelLast);

endmodule

// File: rtl/machine_digit_scan.sv
// Four-digit seven-segment scanner: buffers one pending frame behind a
// valid/ready handshake and commits it only at frame boundaries.
module machine_digit_scan
    import machine_disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 500
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        lz_blank,
    output logic [1:0]  digit_sel,
    output logic        digit_en,
    output logic [3:0]  nibble,
    output logic        dp,
    output logic        frame_tick
);

    logic       slot_end;
    logic [1:0] sel_cur;
    logic [1:0] sel_next;
    logic       show_next;
    logic       frame_end_next;
    logic       frame_end;
    logic       hide;

    disp_word_t pending_q, pending_d;
    disp_word_t display_q, display_d;
    logic       full_q, full_d;

    logic       digit_en_q;
    logic [3:0] nibble_q;
    logic       dp_q;
    logic       frame_tick_q;

    machine_scan_timer #(
        .PRESCALE(PRESCALE),
        .BLANK   (BLANK)
    ) u_timer (
        .clk_i           (system1000),
        .rst_ni          (system1000_rstn),
        .slot_end_o      (slot_end),
        .digit_sel_o     (sel_cur),
        .digit_sel_next_o(sel_next),
        .show_next_o     (show_next),
        .frame_end_next_o(frame_end_next)
    );

    assign frame_end   = slot_end && (sel_cur == 2'(DIGITS - 1));
    assign value_ready = !full_q;

    // Buffer next-state: drain pending into display at frame end, else accept offers.
    // Drain needs full and accept needs empty, so they never collide.
    always_comb begin
        pending_d = pending_q;
        display_d = display_q;
        full_d    = full_q;
        if (frame_end && full_q) begin
            display_d = pending_q;
            full_d    = 1'b0;
        end
        if (value_valid && !full_q) begin
            pending_d = '{dp: dp_in, value: value_in};
            full_d    = 1'b1;
        end
        hide = lz_blank && lz_hidden(display_d.value, sel_next);
    end

    // Buffer registers and output registers, computed from next-state so
    // they line up with the registered digit index.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            pending_q    <= '0;
            display_q    <= '0;
            full_q       <= 1'b0;
            digit_en_q   <= 1'b0;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            display_q    <= display_d;
            full_q       <= full_d;
            digit_en_q   <= show_next && !hide;
            nibble_q     <= display_d.value[{sel_next, 2'b00} +: 4];
            dp_q         <= display_d.dp[sel_next] && !hide;
            frame_tick_q <= frame_end_next;
        end
    end

    assign digit_sel  = sel_cur;
    assign digit_en   = digit_en_q;
    assign nibble     = nibble_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_machine_digit_scan.sv
// Self-checking bench for machine_digit_scan with PRESCALE=8, BLANK=2.
// Expected outputs come from a cycle-count model of the scan schedule
// and a one-deep pending/display buffer model.
module tb_machine_digit_scan;

    localparam int unsigned Prescale = 8;
    localparam int unsigned Blank    = 2;
    localparam int unsigned Frame    = 4 * Prescale;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        value_valid;
    logic        value_ready;
    logic        lz_blank;
    logic [1:0]  digit_sel;
    logic        digit_en;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_tick;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned t;

    // Reference model state
    logic [15:0] m_disp_v, m_pend_v;
    logic [3:0]  m_disp_dp, m_pend_dp;
    logic        m_full, m_acc, m_lz;

    always #5 clk = ~clk;

    machine_digit_scan #(
        .PRESCALE(Prescale),
        .BLANK   (Blank)
    ) dut (
        .system1000     (clk),
        .system1000_rstn(rstn),
        .value_in       (value_in),
        .dp_in          (dp_in),
        .value_valid    (value_valid),
        .value_ready    (value_ready),
        .lz_blank       (lz_blank),
        .digit_sel      (digit_sel),
        .digit_en       (digit_en),
        .nibble         (nibble),
        .dp             (dp),
        .frame_tick     (frame_tick)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_disp_v  = 16'h0;
        m_disp_dp = 4'h0;
        m_pend_v  = 16'h0;
        m_pend_dp = 4'h0;
        m_full    = 1'b0;
        m_acc     = 1'b0;
        m_lz      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".digit_sel"}, 16'(digit_sel), 16'h0);
        chk({tag, ".digit_en"}, 16'(digit_en), 16'h0);
        chk({tag, ".nibble"}, 16'(nibble), 16'h0);
        chk({tag, ".dp"}, 16'(dp), 16'h0);
        chk({tag, ".frame_tick"}, 16'(frame_tick), 16'h0);
        chk({tag, ".value_ready"}, 16'(value_ready), 16'h1);
    endtask

    // Expected outputs for cycle t from the scan schedule and modelled display.
    task automatic check_outputs();
        int          sel;
        logic        show;
        logic        hid;
        logic [15:0] upper;
        sel   = int'((t / Prescale) % 4);
        show  = (t % Prescale) >= Blank;
        upper = m_disp_v >> (4 * sel);
        hid   = m_lz && (sel > 0) && (upper == 16'h0);
        chk("digit_sel", 16'(digit_sel), 16'(sel));
        chk("digit_en", 16'(digit_en), 16'(show && !hid));
        chk("nibble", 16'(nibble), upper & 16'h000f);
        chk("dp", 16'(dp), 16'(m_disp_dp[sel] && !hid));
        chk("frame_tick", 16'(frame_tick), 16'((t % Frame) == Frame - 1));
        chk("value_ready", 16'(value_ready), 16'(!m_full));
    endtask

    // Advance one clock, update the model for that edge, then check.
    task automatic step();
        logic acc;
        @(posedge clk);
        acc = value_valid && !m_full;
        if ((t % Frame) == Frame - 1 && m_full) begin
            m_disp_v  = m_pend_v;
            m_disp_dp = m_pend_dp;
            m_full    = 1'b0;
        end
        if (acc) begin
            m_pend_v  = value_in;
            m_pend_dp = dp_in;
            m_full    = 1'b1;
            m_acc     = 1'b1;
        end
        m_lz = lz_blank;
        t++;
        #1;
        check_outputs();
    endtask

    // Hold an offer until the model says it was taken, bounded.
    task automatic offer(input logic [15:0] v, input logic [3:0] d);
        int waited;
        waited      = 0;
        value_in    = v;
        dp_in       = d;
        value_valid = 1'b1;
        m_acc       = 1'b0;
        while (!m_acc && waited < 3 * Frame) begin
            step();
            waited++;
        end
        value_valid = 1'b0;
        n_assert++;
        assert (m_acc) else begin
            n_fail++;
            $error("FAIL offer_accept t=%0d: observed waited %0d expected accept of %0h", t,
                   waited, v);
        end
    endtask

    initial begin
        logic [15:0] rv;
        rstn        = 1'b1;
        value_in    = 16'h0;
        dp_in       = 4'h0;
        value_valid = 1'b0;
        lz_blank    = 1'b0;
        t           = 0;
        reset_model();

        // Power-on reset, held three cycles
        #1 rstn = 1'b0;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        t    = 0;
        #1 check_outputs();

        // Load 0x1234 at cycle 5, then watch it through the next frame
        repeat (5) step();
        offer(16'h1234, 4'b0100);
        repeat (2 * Frame) step();

        // Back-pressure: second offer stalls until the first drains
        offer(16'hAAAA, 4'b0001);
        offer(16'h5555, 4'b1000);
        repeat (2 * Frame + 4) step();

        // Leading-zero suppression on and off
        lz_blank = 1'b1;
        offer(16'h0070, 4'b1111);
        repeat (2 * Frame) step();
        lz_blank = 1'b0;
        repeat (Frame) step();

        // All zero with every decimal point set
        lz_blank = 1'b1;
        offer(16'h0000, 4'b1111);
        repeat (2 * Frame) step();

        // Randomized values, gaps and lz_blank toggling
        for (int i = 0; i < 24; i++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
            offer(rv, 4'($urandom));
            repeat ($urandom_range(0, 45)) begin
                if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
                step();
            end
        end
        lz_blank = 1'b0;

        // Reset in digit 2 with a value pending; it must never appear
        while ((t % Frame) != 0) step();
        offer(16'hBEEF, 4'b1010);
        while ((t % Frame) != 2 * Prescale + 3) step();
        #2 rstn = 1'b0;
        #1 check_reset("mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        t    = 0;
        reset_model();
        #1 check_outputs();
        repeat (3 * Frame) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
